// File: rtl/bcd_scan_display.sv
// Binary-to-BCD converter (sequential double-dabble, one bit per clock) feeding a
// time-multiplexed common-cathode 7-segment display with optional leading-zero blanking.
module bcd_scan_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1024,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [0:0] {
        S_IDLE,
        S_CONVERT
    } state_t;

    state_t             state_q;
    logic [SR_W-1:0]    sr_q;
    logic [SR_W-1:0]    adj_sr;
    logic [SR_W-1:0]    sr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               valid_q;
    logic [BCD_W-1:0]   bcd_q;

    logic [PRE_W-1:0]   presc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DIGITS-1:0]  en_q;
    logic [DIGITS-1:0]  en_d;
    logic [6:0]         seg_q;
    logic [6:0]         seg_d;
    logic [DIGITS-1:0]  lz;
    logic [3:0]         cur_nib;
    logic               cur_lz;

    function automatic logic [6:0] seg_map(input logic [3:0] n);
        case (n)
            4'd0:    seg_map = 7'h3F;
            4'd1:    seg_map = 7'h06;
            4'd2:    seg_map = 7'h5B;
            4'd3:    seg_map = 7'h4F;
            4'd4:    seg_map = 7'h66;
            4'd5:    seg_map = 7'h6D;
            4'd6:    seg_map = 7'h7D;
            4'd7:    seg_map = 7'h07;
            4'd8:    seg_map = 7'h7F;
            4'd9:    seg_map = 7'h6F;
            default: seg_map = 7'h00;
        endcase
    endfunction

    // One double-dabble step: correct every BCD nibble, then shift the whole register.
    assign adj_sr[WIDTH-1:0] = sr_q[WIDTH-1:0];
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj_sr[WIDTH+4*gi +: 4] = (sr_q[WIDTH+4*gi +: 4] >= 4'd5)
                                           ? sr_q[WIDTH+4*gi +: 4] + 4'd3
                                           : sr_q[WIDTH+4*gi +: 4];
        end
    endgenerate
    assign sr_d = {adj_sr[SR_W-2:0], 1'b0};

    // The final step writes the display register directly, so the cycle that shows
    // bcd_valid is already idle and can accept the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        sr_q    <= {{BCD_W{1'b0}}, value};
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        bcd_q   <= sr_d[SR_W-1 -: BCD_W];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // lz[i]: digit i and every digit above it are zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == DIGITS - 1) begin : g_top
                assign lz[gi] = (bcd_q[4*gi +: 4] == 4'd0);
            end else begin : g_mid
                assign lz[gi] = lz[gi+1] && (bcd_q[4*gi +: 4] == 4'd0);
            end
            assign en_d[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        cur_nib = 4'd0;
        cur_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = bcd_q[4*i +: 4];
                cur_lz  = lz[i];
            end
        end
        seg_d = seg_map(cur_nib);
        if ((BLANK_LZ != 0) && (idx_q != '0) && cur_lz) begin
            seg_d = 7'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            en_q    <= DIGITS'(1);
            seg_q   <= 7'h00;
        end else begin
            en_q  <= en_d;
            seg_q <= seg_d;
            if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    assign busy      = busy_q;
    assign bcd_valid = valid_q;
    assign bcd       = bcd_q;
    assign segments  = seg_q;
    assign digit_en  = en_q;

endmodule
